if_id_hazard: RTL and testbench
===============================

# if_id_hazard

IF/ID pipeline register with integrated load-use hazard detection, branch flush and start sequencing. It sits between instruction fetch and the ID-stage decoder: it holds the fetched instruction and PC, and produces the PC-write enable and the `noop_o` bubble request that drives the Control unit's `NoOp_i`. It is the single owner of front-end stall and flush behaviour.

## Interface
- `XLEN`, 32, data/PC width
- `clk_i` input 1: clock, rising edge
- `rst_i` input 1: asynchronous, active-low reset
- `start_i` input 1: run enable; level-sensitive
- `pc_i` input XLEN: PC of the instruction being fetched
- `instr_i` input 32: instruction from instruction memory
- `flush_i` input 1: branch taken in ID; discard the fetched instruction
- `ex_memread_i` input 1: ID/EX MemRead
- `ex_rd_i` input 5: ID/EX destination register
- `pc_write_o` output 1: PC register update enable
- `noop_o` output 1: bubble request to Control (`NoOp_i`)
- `pc_o` output XLEN: IF/ID PC
- `instr_o` output 32: IF/ID instruction
- `valid_o` output 1: IF/ID holds a real instruction
- `stall_cnt_o` output 32: stall cycles (macro-gated)
- `flush_cnt_o` output 32: flush events (macro-gated)

## Operation
- FSM states are IDLE and RUN.
  - Reset enters IDLE.
  - IDLE→RUN when `start_i`=1 at a clock edge.
  - RUN→IDLE when `start_i`=0 at a clock edge.
- In IDLE:
  - `pc_write_o`=0 and `noop_o`=0.
  - The IF/ID register loads a bubble: `instr_o`=32'h0, `pc_o`=0, `valid_o`=0.
- Source-register use is decoded from `instr_o[6:0]`:
  - rs1 (`instr_o[19:15]`) is used for R-type, I-type, lw, sw and beq.
  - rs2 (`instr_o[24:20]`) is used for R-type, sw and beq.
  - All other opcodes use no source registers.
- Hazard condition: state RUN and `valid_o` and `ex_memread_i` and `ex_rd_i`≠0 and `ex_rd_i` equals a used rs1 or rs2.
- On a hazard:
  - `noop_o`=1 and `pc_write_o`=0.
  - IF/ID holds its contents.
- Flush, taken only when there is no hazard: IF/ID loads the bubble and `pc_write_o`=1.
- Priority is reset > IDLE > hazard > flush > normal. A `flush_i` coinciding with a hazard is ignored, because Control suppresses Branch under `noop_o`.
- Normal RUN operation: IF/ID loads `pc_i`/`instr_i`, `valid_o`=1, `pc_write_o`=1.
- The bubble encoding 32'h0 decodes in Control to all-zero controls.

## Timing
- `noop_o` and `pc_write_o` are combinational from the IF/ID contents, the state and the `ex_*` inputs. They are valid in the same cycle.
- IF/ID, the state and the counters update on the rising edge of `clk_i`.
- Fetch-to-decode latency is 1 cycle.
- A load-use hazard costs exactly 1 stall cycle: the next cycle the lw has moved to EX/MEM, so the condition drops.
- Reset values:
  - State = IDLE.
  - `instr_o`=0, `pc_o`=0, `valid_o`=0.
  - `noop_o`=0, `pc_write_o`=0.
  - Both counters = 0.
- Reset asserted mid-stall or mid-flush clears everything immediately, asynchronously.
- Deasserting `start_i` mid-stall: the next edge goes to IDLE and loads a bubble.

## Configuration
- `IF_ID_HAZARD_PERF_EN` defined:
  - `stall_cnt_o` increments on each cycle `noop_o`=1.
  - `flush_cnt_o` increments on each accepted flush.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: no counter registers exist, and both outputs are tied to 0.

## Structure
- Shared package holds:
  - opcode constants `OPC_RTYPE` (0110011), `OPC_ITYPE` (0010011), `OPC_LW` (0000011), `OPC_SW` (0100011), `OPC_BEQ` (1100011). These are shared with Control.
  - `INSTR_BUBBLE` = 32'h0.
  - State enum {IDLE, RUN}.
- One combinational sub-module, `load_use_detect`: takes the opcode, rs1, rs2, `ex_memread` and `ex_rd`, and returns the hazard flag.

## Test plan
- Reset with `start_i`=0 → `instr_o`=0, `valid_o`=0, `pc_write_o`=0; after `start_i`=1 and one edge, `pc_write_o`=1.
- IF/ID holds 0x00528333 (add x6,x5,x5), `ex_memread_i`=1, `ex_rd_i`=5 → `noop_o`=1, `pc_write_o`=0, IF/ID unchanged. The next cycle, with `ex_memread_i`=0, → `noop_o`=0.
- Same instruction with `ex_rd_i`=0 and `ex_memread_i`=1 → no stall. Same with `ex_memread_i`=1 and `ex_rd_i`=7 → no stall.
- IF/ID holds lw x5,0(x0) (0x00002283), `ex_memread_i`=1, `ex_rd_i`=0 or 5 → no stall (rs2 unused, rs1=x0).
- `flush_i`=1 with `pc_i`=0x10 → next cycle `instr_o`=0, `valid_o`=0, `flush_cnt_o`=1 (macro on). `flush_i`=1 together with a hazard → IF/ID held, `flush_cnt_o` unchanged.
- Assert `rst_i`=0 asynchronously mid-stall → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/if_id_hazard_pkg.sv
// Shared front-end constants: opcodes, bubble encoding, IF/ID state.
// Also holds the source-register usage helpers used by hazard decode.
package if_id_hazard_pkg;

    localparam logic [6:0]  OPC_RTYPE    = 7'b0110011;
    localparam logic [6:0]  OPC_ITYPE    = 7'b0010011;
    localparam logic [6:0]  OPC_LW       = 7'b0000011;
    localparam logic [6:0]  OPC_SW       = 7'b0100011;
    localparam logic [6:0]  OPC_BEQ      = 7'b1100011;
    localparam logic [31:0] INSTR_BUBBLE = 32'h0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] opc);
        unique case (opc)
            OPC_RTYPE, OPC_ITYPE, OPC_LW,
            OPC_SW, OPC_BEQ: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        unique case (opc)
            OPC_RTYPE, OPC_SW, OPC_BEQ: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/if_id_hazard_load_use_detect.sv
// Combinational load-use detector for the instruction held in IF/ID.
// Ports: i_opcode/i_rs1/i_rs2 from IF/ID, i_ex_memread/i_ex_rd from ID/EX, o_hazard.
module load_use_detect
    import if_id_hazard_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    output logic       o_hazard
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = uses_rs1(i_opcode) && (i_ex_rd == i_rs1);
    assign w_hit_rs2 = uses_rs2(i_opcode) && (i_ex_rd == i_rs2);

    // x0 is never a real dependency
    assign o_hazard = i_ex_memread && (i_ex_rd != 5'd0)
                      && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID register with load-use stall, branch flush and IDLE/RUN sequencing.
// Ports: clk_i, rst_i (async active-low), start_i, pc_i, instr_i, flush_i,
//   ex_memread_i, ex_rd_i -> pc_write_o, noop_o, pc_o, instr_o, valid_o,
//   stall_cnt_o, flush_cnt_o (counters exist only with IF_ID_HAZARD_PERF_EN).
module if_id_hazard
    import if_id_hazard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            flush_i,
    input  logic            ex_memread_i,
    input  logic [4:0]      ex_rd_i,
    output logic            pc_write_o,
    output logic            noop_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;

    logic            w_run;
    logic            w_lu_hit;
    logic            w_hazard;

    assign w_run = (r_state == RUN);

    load_use_detect u_lud (
        .i_opcode     (r_instr[6:0]),
        .i_rs1        (r_instr[19:15]),
        .i_rs2        (r_instr[24:20]),
        .i_ex_memread (ex_memread_i),
        .i_ex_rd      (ex_rd_i),
        .o_hazard     (w_lu_hit)
    );

    assign w_hazard   = w_run && r_valid && w_lu_hit;
    assign noop_o     = w_hazard;
    assign pc_write_o = w_run && !w_hazard;

    assign pc_o    = r_pc;
    assign instr_o = r_instr;
    assign valid_o = r_valid;

    // Dropping start_i while running (even mid-stall) also bubbles IF/ID
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_instr <= INSTR_BUBBLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= start_i ? RUN : IDLE;
            if (!w_run || !start_i) begin
                r_pc    <= '0;
                r_instr <= INSTR_BUBBLE;
                r_valid <= 1'b0;
            end else if (w_hazard) begin
                r_pc    <= r_pc;
                r_instr <= r_instr;
                r_valid <= r_valid;
            end else if (flush_i) begin
                r_pc    <= '0;
                r_instr <= INSTR_BUBBLE;
                r_valid <= 1'b0;
            end else begin
                r_pc    <= pc_i;
                r_instr <= instr_i;
                r_valid <= 1'b1;
            end
        end
    end

`ifdef IF_ID_HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_flush_acc;

    assign w_flush_acc = w_run && start_i && !w_hazard && flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush_acc && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Self-checking bench for if_id_hazard: directed plan steps, then random
// traffic against a behavioural model of the front-end rules.
module tb_if_id_hazard;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LW_OP = 7'b0000011;
    localparam logic [6:0] SW_OP = 7'b0100011;
    localparam logic [6:0] BQ_OP = 7'b1100011;
    localparam logic [6:0] LUI   = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        flush_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic        pc_write_o;
    logic        noop_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;

    bit          m_run;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_sc;
    logic [31:0] m_fc;

    always #5 clk = ~clk;

    if_id_hazard #(.XLEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .flush_i      (flush_i),
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .pc_write_o   (pc_write_o),
        .noop_o       (noop_o),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .valid_o      (valid_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    function automatic bit reads_rs1(input logic [6:0] o);
        return (o == R_OP) || (o == I_OP) || (o == LW_OP)
            || (o == SW_OP) || (o == BQ_OP);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] o);
        return (o == R_OP) || (o == SW_OP) || (o == BQ_OP);
    endfunction

    function automatic bit m_hazard();
        bit dep;
        dep = (reads_rs1(m_instr[6:0]) && ex_rd_i == m_instr[19:15])
           || (reads_rs2(m_instr[6:0]) && ex_rd_i == m_instr[24:20]);
        return m_run && m_valid && ex_memread_i && (ex_rd_i != 0) && dep;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_valid = 0; m_pc = 0; m_instr = 0;
        m_sc = 0; m_fc = 0;
    endtask

    task automatic check_all(input string tag);
        bit hz;
        hz = m_hazard();
        chk({tag, ".noop"}, {31'd0, noop_o}, {31'd0, hz});
        chk({tag, ".pcw"}, {31'd0, pc_write_o}, {31'd0, m_run && !hz});
        chk({tag, ".pc"}, pc_o, m_pc);
        chk({tag, ".instr"}, instr_o, m_instr);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, m_valid});
`ifdef IF_ID_HAZARD_PERF_EN
        chk({tag, ".scnt"}, stall_cnt_o, m_sc);
        chk({tag, ".fcnt"}, flush_cnt_o, m_fc);
`else
        chk({tag, ".scnt"}, stall_cnt_o, 32'd0);
        chk({tag, ".fcnt"}, flush_cnt_o, 32'd0);
`endif
    endtask

    task automatic drive(input bit st, input logic [31:0] pc,
                         input logic [31:0] ins, input bit fl,
                         input bit mr, input logic [4:0] rd);
        start_i = st; pc_i = pc; instr_i = ins;
        flush_i = fl; ex_memread_i = mr; ex_rd_i = rd;
    endtask

    // Check outputs for the current inputs, then advance one clock
    task automatic cycle(input string tag);
        bit hz;
        bit nrun;
        #1;
        check_all(tag);
        hz = m_hazard();
        nrun = start_i;
        if (hz && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        if (!m_run || !start_i) begin
            m_pc = 0; m_instr = 0; m_valid = 0;
        end else if (hz) begin
            // stall: IF/ID keeps its instruction
        end else if (flush_i) begin
            m_pc = 0; m_instr = 0; m_valid = 0;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end else begin
            m_pc = pc_i; m_instr = instr_i; m_valid = 1;
        end
        m_run = nrun;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [6];
        logic [31:0] w;
        ops[0] = R_OP; ops[1] = I_OP; ops[2] = LW_OP;
        ops[3] = SW_OP; ops[4] = BQ_OP; ops[5] = LUI;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 5)];
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    localparam logic [31:0] ADD = 32'h00528333;
    localparam logic [31:0] LWI = 32'h00002283;
    localparam logic [31:0] NOP = 32'h00000013;

    initial begin
        m_reset();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_i = 1'b1;
        cycle("idle");
        drive(1, 32'h100, NOP, 0, 0, 0);
        cycle("start");
        #1;
        chk("start.pcw1", {31'd0, pc_write_o}, 32'd1);

        drive(1, 32'h100, ADD, 0, 0, 0);
        cycle("ld_add");
        drive(1, 32'h104, NOP, 0, 1, 5);
        #1;
        chk("plan.noop1", {31'd0, noop_o}, 32'd1);
        chk("plan.pcw0", {31'd0, pc_write_o}, 32'd0);
        cycle("stall");
        chk("plan.held", instr_o, ADD);
        drive(1, 32'h100, ADD, 0, 0, 5);
        #1;
        chk("plan.nostall", {31'd0, noop_o}, 32'd0);
        cycle("release");
        drive(1, 32'h100, ADD, 0, 1, 0);
        cycle("rd_x0");
        drive(1, 32'h100, ADD, 0, 1, 7);
        cycle("rd_x7");
        drive(1, 32'h200, LWI, 0, 0, 0);
        cycle("ld_lw");
        drive(1, 32'h200, LWI, 0, 1, 0);
        cycle("lw_rd0");
        drive(1, 32'h200, LWI, 0, 1, 5);
        cycle("lw_rd5");
        drive(1, 32'h10, ADD, 1, 0, 0);
        cycle("flush");
        chk("plan.fl_instr", instr_o, 32'd0);
        chk("plan.fl_valid", {31'd0, valid_o}, 32'd0);
`ifdef IF_ID_HAZARD_PERF_EN
        chk("plan.fl_cnt", flush_cnt_o, 32'd1);
`endif
        drive(1, 32'h300, ADD, 0, 0, 0);
        cycle("ld_add2");
        drive(1, 32'h304, NOP, 1, 1, 5);
        cycle("fl_hz");
        chk("plan.flhz_held", instr_o, ADD);

        // async reset in the middle of a stall
        drive(1, 32'h304, NOP, 0, 1, 5);
        #1;
        chk("pre_rst.noop", {31'd0, noop_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        drive(1, 32'h400, NOP, 0, 0, 0);
        cycle("restart");
        drive(1, 32'h400, ADD, 0, 0, 0);
        cycle("ld_add3");
        drive(0, 32'h404, NOP, 0, 1, 5);
        cycle("stop_stall");
        chk("stop.valid", {31'd0, valid_o}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) != 0, $urandom,
                  rnd_instr(), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
